// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command controller: default widths,
// frame command codes and the controller state encoding.
package alu_ctrl_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int FUN_WIDTH_DEF    = 4;
  localparam int RESP_TIMEOUT_DEF = 4;

  localparam logic [7:0] CMD_ALU_OPS  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOOP = 8'hDD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_GET_FUN,
    ST_EXEC,
    ST_WAIT_RES,
    ST_SEND_LO,
    ST_SEND_HI
  } ctrl_state_t;

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Parses RX command frames, fires one ALU operation, waits (bounded) for the
// registered result and returns it low byte first over the TX valid/busy link.
//
// state       | meaning
// ST_IDLE     | waiting for a command byte
// ST_GET_A    | waiting for operand A
// ST_GET_B    | waiting for operand B
// ST_GET_FUN  | waiting for the function byte
// ST_EXEC     | ALU_EN high for this single cycle
// ST_WAIT_RES | waiting for ALU_valid, bounded by the timeout counter
// ST_SEND_LO  | offering result low byte
// ST_SEND_HI  | offering result high byte
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int OUT_WIDTH    = 2*DATA_WIDTH,
  parameter int FUN_WIDTH    = FUN_WIDTH_DEF,
  parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] RX_data,
  input  logic                  RX_valid,
  output logic                  ALU_EN,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  input  logic [OUT_WIDTH-1:0]  ALU_out,
  input  logic                  ALU_valid,
  output logic [DATA_WIDTH-1:0] TX_data,
  output logic                  TX_valid,
  input  logic                  TX_busy,
  output logic                  cmd_err
);

  localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);

  ctrl_state_t           state, state_nxt;
  logic [DATA_WIDTH-1:0] reg_a, reg_b;
  logic [FUN_WIDTH-1:0]  reg_fun;
  logic [OUT_WIDTH-1:0]  res;
  logic [CNT_W-1:0]      tmo_cnt;
  logic                  ld_a, ld_b, ld_fun, ld_res, err;
  logic                  is_ops, is_noop;

  assign is_ops  = (RX_data == DATA_WIDTH'(CMD_ALU_OPS));
  assign is_noop = (RX_data == DATA_WIDTH'(CMD_ALU_NOOP));

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= ST_IDLE;
      reg_a   <= '0;
      reg_b   <= '0;
      reg_fun <= '0;
      res     <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (ld_a)   reg_a   <= RX_data;
      if (ld_b)   reg_b   <= RX_data;
      if (ld_fun) reg_fun <= RX_data[FUN_WIDTH-1:0];
      if (ld_res) res     <= ALU_out;
      // Down-counter loaded while in EXEC so WAIT_RES starts from a full budget.
      if (state == ST_EXEC)
        tmo_cnt <= CNT_W'(RESP_TIMEOUT - 1);
      else if (state == ST_WAIT_RES && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_fun    = 1'b0;
    ld_res    = 1'b0;
    err       = 1'b0;
    ALU_EN    = 1'b0;
    TX_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (RX_valid) begin
          if (is_ops)       state_nxt = ST_GET_A;
          else if (is_noop) state_nxt = ST_GET_FUN;
          else              err       = 1'b1;
        end
      end
      ST_GET_A: begin
        if (RX_valid) begin
          ld_a      = 1'b1;
          state_nxt = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (RX_valid) begin
          ld_b      = 1'b1;
          state_nxt = ST_GET_FUN;
        end
      end
      ST_GET_FUN: begin
        if (RX_valid) begin
          ld_fun    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ALU_EN    = 1'b1;
        err       = RX_valid;
        state_nxt = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        err = RX_valid;
        if (ALU_valid) begin
          ld_res    = 1'b1;
          state_nxt = ST_SEND_LO;
        end else if (tmo_cnt == '0) begin
          err       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_SEND_LO: begin
        TX_valid = 1'b1;
        err      = RX_valid;
        if (!TX_busy) state_nxt = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        TX_valid = 1'b1;
        err      = RX_valid;
        if (!TX_busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Gated so an RX strobe during reset cannot leak an error pulse.
  assign cmd_err = err & ~Reset;

  assign ALU_A   = reg_a;
  assign ALU_B   = reg_b;
  assign ALU_FUN = reg_fun;
  assign TX_data = (state == ST_SEND_HI) ? res[OUT_WIDTH-1:DATA_WIDTH]
                                         : res[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl with a behavioural registered ALU whose
// response delay can be stretched or suppressed.
module tb_alu_cmd_ctrl;

  logic        CLK, Reset;
  logic [7:0]  RX_data;
  logic        RX_valid;
  logic        ALU_EN;
  logic [7:0]  ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_out;
  logic        ALU_valid;
  logic [7:0]  TX_data;
  logic        TX_valid;
  logic        TX_busy;
  logic        cmd_err;

  alu_cmd_ctrl dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .RX_data  (RX_data),
    .RX_valid (RX_valid),
    .ALU_EN   (ALU_EN),
    .ALU_A    (ALU_A),
    .ALU_B    (ALU_B),
    .ALU_FUN  (ALU_FUN),
    .ALU_out  (ALU_out),
    .ALU_valid(ALU_valid),
    .TX_data  (TX_data),
    .TX_valid (TX_valid),
    .TX_busy  (TX_busy),
    .cmd_err  (cmd_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0, n_miss = 0;
  int cyc = 0, err_cnt = 0, en_cnt = 0, err_cyc = 0, en_cyc = 0;
  int tx_extra = 0, n_ops_exp = 0;
  logic [7:0] q_tx[$];
  logic [7:0] exp_a = 8'h00, exp_b = 8'h00;
  logic [3:0] exp_fun = 4'h0;
  bit  alu_ena = 1'b1;
  int  alu_delay = 1;
  int  dly = 0;
  logic [15:0] pend = 16'h0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'h0:    return {8'h00, a} + {8'h00, b};
      4'h1:    return {8'h00, a} - {8'h00, b};
      4'h2:    return 16'(a) * 16'(b);
      4'h3:    return {8'h00, a & b};
      4'h4:    return {8'h00, a | b};
      4'h5:    return {8'h00, a ^ b};
      default: return 16'h0000;
    endcase
  endfunction

  // Behavioural ALU: result registered alu_delay cycles after the enable edge.
  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      ALU_valid <= 1'b0;
      ALU_out   <= 16'h0;
      dly       <= 0;
    end else begin
      ALU_valid <= 1'b0;
      if (ALU_EN && alu_ena) begin
        if (alu_delay <= 1) begin
          ALU_valid <= 1'b1;
          ALU_out   <= alu_f(ALU_A, ALU_B, ALU_FUN);
        end else begin
          pend <= alu_f(ALU_A, ALU_B, ALU_FUN);
          dly  <= alu_delay - 1;
        end
      end else if (dly != 0) begin
        dly <= dly - 1;
        if (dly == 1) begin
          ALU_valid <= 1'b1;
          ALU_out   <= pend;
        end
      end
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (cmd_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (ALU_EN) begin
      en_cnt = en_cnt + 1;
      en_cyc = cyc;
      check_val("alu_a", ALU_A, exp_a);
      check_val("alu_b", ALU_B, exp_b);
      check_val("alu_fun", ALU_FUN, exp_fun);
    end
    if (TX_valid && !TX_busy) begin
      if (q_tx.size() == 0) tx_extra = tx_extra + 1;
      else check_val("tx_byte", TX_data, q_tx.pop_front());
    end
  end

  task automatic rx(input logic [7:0] b);
    RX_data  = b;
    RX_valid = 1'b1;
    @(posedge CLK); #1;
    RX_valid = 1'b0;
  endtask

  task automatic push_exp();
    logic [15:0] r;
    r = alu_f(exp_a, exp_b, exp_fun);
    q_tx.push_back(r[7:0]);
    q_tx.push_back(r[15:8]);
  endtask

  task automatic send_ops(input logic [7:0] a, input logic [7:0] b, input logic [7:0] fb, input bit expect_tx);
    exp_a = a; exp_b = b; exp_fun = fb[3:0];
    n_ops_exp++;
    if (expect_tx) push_exp();
    rx(8'hCC); rx(a); rx(b); rx(fb);
  endtask

  task automatic send_noop(input logic [7:0] fb);
    exp_fun = fb[3:0];
    n_ops_exp++;
    push_exp();
    rx(8'hDD); rx(fb);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && q_tx.size() != 0; k++) @(posedge CLK);
    #1;
    repeat (2) @(posedge CLK);
    #1;
    check_val("drain", q_tx.size(), 0);
  endtask

  task automatic wait_txv();
    for (int k = 0; k < 20 && !TX_valid; k++) begin
      @(posedge CLK); #1;
    end
    check_val("txv_seen", TX_valid, 1);
  endtask

  int e0, n0;

  initial begin
    Reset = 1'b1; RX_data = 8'h00; RX_valid = 1'b0; TX_busy = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_alu_en", ALU_EN, 0);
    check_val("rst_txv", TX_valid, 0);
    check_val("rst_err", cmd_err, 0);
    check_val("rst_a", ALU_A, 0);
    check_val("rst_b", ALU_B, 0);
    check_val("rst_fun", ALU_FUN, 0);
    check_val("rst_txd", TX_data, 0);
    Reset = 1'b0;
    @(posedge CLK); #1;

    // Basic add with latency checks
    send_ops(8'h0A, 8'h05, 8'h00, 1);
    check_val("lat_en", ALU_EN, 1);
    @(posedge CLK); #1;
    check_val("lat_en_off", ALU_EN, 0);
    @(posedge CLK); #1;
    check_val("lat_txv", TX_valid, 1);
    check_val("lat_txd", TX_data, 8'h0F);
    @(posedge CLK); #1;
    check_val("lat_hi_v", TX_valid, 1);
    check_val("lat_hi_d", TX_data, 8'h00);
    wait_drain();

    // Multiply, then operand reuse, then ignored upper FUN bits
    send_ops(8'hFF, 8'hFF, 8'h02, 1);
    wait_drain();
    send_noop(8'h00);
    wait_drain();
    send_noop(8'hF5);
    wait_drain();

    // Unknown leading byte
    e0 = err_cnt; n0 = en_cnt;
    rx(8'h55);
    repeat (3) @(posedge CLK);
    #1;
    check_val("bad_cmd_err", err_cnt - e0, 1);
    check_val("bad_cmd_en", en_cnt - n0, 0);
    send_ops(8'h03, 8'h04, 8'h00, 1);
    wait_drain();

    // Transmitter stall, with a stray RX byte during SEND_LO
    TX_busy = 1'b1;
    e0 = err_cnt;
    send_ops(8'h12, 8'h34, 8'h03, 1);
    wait_txv();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rx(8'hCC);
      else begin
        @(posedge CLK); #1;
      end
      check_val("busy_hold_v", TX_valid, 1);
      check_val("busy_hold_d", TX_data, 8'h10);
    end
    check_val("busy_rx_err", err_cnt - e0, 1);
    TX_busy = 1'b0;
    wait_drain();

    // Missing ALU response
    alu_ena = 1'b0;
    e0 = err_cnt;
    send_ops(8'h01, 8'h01, 8'h00, 0);
    for (int k = 0; k < 20 && err_cnt == e0; k++) @(posedge CLK);
    #1;
    repeat (3) @(posedge CLK);
    #1;
    check_val("tmo_err", err_cnt - e0, 1);
    check_val("tmo_dist", err_cyc - en_cyc, 4);
    check_val("tmo_txv", TX_valid, 0);
    alu_ena = 1'b1;
    send_ops(8'h20, 8'h22, 8'h00, 1);
    wait_drain();

    // Response on the last allowed WAIT_RES cycle
    alu_delay = 4;
    e0 = err_cnt;
    send_ops(8'h07, 8'h06, 8'h02, 1);
    wait_drain();
    check_val("late_ok_err", err_cnt - e0, 0);
    alu_delay = 1;

    // Reset while the high byte is stalled
    TX_busy = 1'b1;
    send_ops(8'h10, 8'h10, 8'h02, 1);
    wait_txv();
    TX_busy = 1'b0;
    @(posedge CLK); #1;
    TX_busy = 1'b1;
    @(posedge CLK); #1;
    check_val("hi_hold_v", TX_valid, 1);
    check_val("hi_hold_d", TX_data, 8'h01);
    #2 Reset = 1'b1;
    #1;
    check_val("arst_txv", TX_valid, 0);
    check_val("arst_en", ALU_EN, 0);
    check_val("arst_err", cmd_err, 0);
    check_val("arst_a", ALU_A, 0);
    check_val("arst_b", ALU_B, 0);
    check_val("arst_fun", ALU_FUN, 0);
    check_val("arst_txd", TX_data, 0);
    q_tx.delete();
    exp_a = 8'h00; exp_b = 8'h00; exp_fun = 4'h0;
    @(posedge CLK); #1;
    Reset = 1'b0;
    TX_busy = 1'b0;
    @(posedge CLK); #1;
    send_noop(8'h00);
    wait_drain();

    check_val("tx_extra", tx_extra, 0);
    check_val("en_total", en_cnt, n_ops_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
